// File: rtl/lm32_ram_fifo.sv
// ============================================================================
// Module   : lm32_ram_fifo
// Summary  : Single-clock FIFO on a registered-read-address array. The reader
//            side is a valid/ready stream that sustains one pop per cycle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lm32_ram_fifo #(
  parameter int addr_width = 4,
  parameter int data_width = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [data_width-1:0] push_data_i,
  output logic                  full_o,
  output logic [data_width-1:0] rdata_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [addr_width:0]   level_o
);

  localparam int                    c_depth      = 1 << addr_width;
  localparam logic [addr_width:0]   c_full_count = (addr_width+1)'(c_depth);
  localparam logic [addr_width:0]   c_count_one  = (addr_width+1)'(1);
  localparam logic [addr_width-1:0] c_ptr_one    = addr_width'(1);

  logic [data_width-1:0] r_mem [c_depth];

  logic [addr_width-1:0] r_wptr;
  logic [addr_width-1:0] r_rptr;
  logic [addr_width-1:0] r_raddr;
  logic [addr_width:0]   r_count;
  logic                  r_full;
  logic                  r_pending;
  logic                  r_out_valid;
  logic [data_width-1:0] r_out_data;
  logic                  r_skid_valid;
  logic [data_width-1:0] r_skid_data;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_fetch;
  logic [1:0]            w_occupancy;
  logic [addr_width:0]   w_count_next;
  logic [data_width-1:0] w_rd_data;

  assign w_push    = push_i & ~r_full;
  assign w_pop     = r_out_valid & ready_i;
  assign w_rd_data = r_mem[r_raddr];

  // Words already committed to the output side after this edge: in flight plus
  // buffered, minus the one leaving. Never exceeds two.
  assign w_occupancy = {1'b0, r_pending} + {1'b0, r_out_valid}
                     + {1'b0, r_skid_valid} - {1'b0, w_pop};
  assign w_fetch     = (r_wptr != r_rptr) && (w_occupancy < 2'd2);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_count_one;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - c_count_one;
    end
  end

  // Array storage is deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_full_count);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rptr    <= '0;
      r_raddr   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_fetch;
      if (w_fetch) begin
        r_raddr <= r_rptr;
        r_rptr  <= r_rptr + c_ptr_one;
      end
    end
  end

  // The skid word is always older than a landing fetch, so it moves forward
  // first whenever the output register frees up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (r_pending) begin
      if (!r_out_valid || w_pop) begin
        r_out_valid <= 1'b1;
        if (r_skid_valid) begin
          r_out_data  <= r_skid_data;
          r_skid_data <= w_rd_data;
        end else begin
          r_out_data  <= w_rd_data;
        end
      end else begin
        r_skid_data  <= w_rd_data;
        r_skid_valid <= 1'b1;
      end
    end else if (!r_out_valid || w_pop) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign full_o  = r_full;
  assign rdata_o = r_out_data;
  assign valid_o = r_out_valid;
  assign level_o = r_count;

endmodule

`default_nettype wire

// File: tb/tb_lm32_ram_fifo.sv
// ============================================================================
// Module   : tb_lm32_ram_fifo
// Summary  : Randomized bench for lm32_ram_fifo against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lm32_ram_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        push_i = 1'b0;
  logic [31:0] push_data_i = '0;
  logic        full_o;
  logic [31:0] rdata_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [4:0]  level_o;

  lm32_ram_fifo #(.addr_width(4), .data_width(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .rdata_o     (rdata_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          e;
  } ent_t;

  ent_t q[$];
  int   edge_cnt = 0;
  bit   cmp_en   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a word is visible exactly two edges after its push (or as soon as
  // the words ahead of it leave), one word leaves per pop.
  function automatic bit model_valid();
    return (q.size() > 0) && (edge_cnt - q[0].e >= 2);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst_i) begin
        q.delete();
      end else begin
        int  sz;
        bit  mv;
        sz = q.size();
        mv = model_valid();
        if (mv && ready_i) void'(q.pop_front());
        if (push_i && sz < DEPTH) q.push_back('{d: push_data_i, e: edge_cnt + 1});
      end
      edge_cnt++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("valid", {31'b0, valid_o}, {31'b0, model_valid()});
        chk("level", {27'b0, level_o}, q.size());
        chk("full", {31'b0, full_o}, {31'b0, q.size() == DEPTH});
        if (model_valid() && valid_o) chk("rdata", rdata_o, q[0].d);
      end
    end
  end

  task automatic drive(input bit p, input logic [31:0] d, input bit r);
    push_i      = p;
    push_data_i = d;
    ready_i     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((level_o != 0 || valid_o) && n < 64) begin
      drive(1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("drain_empty", {27'b0, level_o}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    rst_i = 1'b0;
    cmp_en = 1'b1;
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_full", {31'b0, full_o}, 32'h0);
    chk("rst_level", {27'b0, level_o}, 32'h0);

    // single word latency
    drive(1, 32'hA5, 1);
    chk("t1_lat0", {31'b0, valid_o}, 32'h0);
    chk("t1_lvl", {27'b0, level_o}, 32'h1);
    drive(0, 0, 1);
    chk("t1_lat1", {31'b0, valid_o}, 32'h0);
    drive(0, 0, 1);
    chk("t1_lat2", {31'b0, valid_o}, 32'h1);
    chk("t1_data", rdata_o, 32'hA5);
    drive(0, 0, 1);
    chk("t1_popped", {31'b0, valid_o}, 32'h0);
    chk("t1_lvl0", {27'b0, level_o}, 32'h0);

    // fill to full, overflow dropped, ordered drain
    for (int i = 0; i < 16; i++) drive(1, i, 0);
    chk("t2_full", {31'b0, full_o}, 32'h1);
    chk("t2_lvl", {27'b0, level_o}, 32'd16);
    drive(1, 32'hFF, 0);
    chk("t2_drop", {27'b0, level_o}, 32'd16);
    for (int k = 0; k < 16; k++) begin
      int w = 0;
      while (!valid_o && w < 8) begin
        drive(0, 0, 1);
        w++;
      end
      chk("t2_order", rdata_o, k);
      drive(0, 0, 1);
    end
    chk("t2_empty", {27'b0, level_o}, 32'h0);
    drain();

    // push while full with a simultaneous pop is dropped
    for (int i = 0; i < 16; i++) drive(1, 32'h200 + i, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("t3_full", {31'b0, full_o}, 32'h1);
    drive(1, 32'hEE, 1);
    chk("t3_lvl", {27'b0, level_o}, 32'd15);
    chk("t3_notfull", {31'b0, full_o}, 32'h0);
    drain();

    // continuous streaming across pointer wrap
    for (int i = 0; i < 100; i++) begin
      drive(1, 32'h1000 + i, 1);
      if (i >= 2) chk("t4_nogap", {31'b0, valid_o}, 32'h1);
      if (i >= 3) chk("t4_seq", rdata_o, 32'h1000 + i - 2);
    end
    drain();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 1) == 1);
    end
    drain();

    // reset with words buffered and a fetch in flight
    for (int i = 0; i < 7; i++) drive(1, 32'h300 + i, 0);
    drive(1, 32'h77, 1);
    chk("t6_lvl7", {27'b0, level_o}, 32'd7);
    rst_i = 1'b1;
    drive(0, 0, 0);
    rst_i = 1'b0;
    chk("t6_valid", {31'b0, valid_o}, 32'h0);
    chk("t6_level", {27'b0, level_o}, 32'h0);
    chk("t6_full", {31'b0, full_o}, 32'h0);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("t6_quiet", {31'b0, valid_o}, 32'h0);
    drive(1, 32'h3C, 1);
    drive(0, 0, 1);
    drive(0, 0, 1);
    chk("t6_first_v", {31'b0, valid_o}, 32'h1);
    chk("t6_first_d", rdata_o, 32'h3C);
    drain();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
